// File: rtl/parity_frame_checker.sv
// Serial frame receiver: start(0), N data bits LSB first, parity, stop(1).
// Advances only on bit_valid cycles; reports data plus parity/framing errors.
module parity_frame_checker #(
  parameter int N   = 8,
  parameter bit ODD = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_in,
  input  logic         bit_valid,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  output logic         parity_error,
  output logic         frame_error,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt_p0;
  logic [N-1:0]  shift_p0;
  logic          acc_p0;
  logic          perr_p0;

  function automatic logic exp_parity(input logic acc);
    return acc ^ ODD;
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else if (bit_valid)
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!serial_in) next_state = DATA;
      DATA:    if (cnt_p0 == LAST) next_state = PARITY;
      PARITY:  next_state = STOP;
      STOP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Stage p0: bit capture, parity accumulation, and frame completion outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0       <= '0;
      acc_p0       <= 1'b0;
      perr_p0      <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (bit_valid) begin
        case (state)
          IDLE: begin
            if (!serial_in) begin
              cnt_p0 <= '0;
              acc_p0 <= 1'b0;
            end
          end
          DATA: begin
            for (int i = 0; i < N; i++)
              if (cnt_p0 == CW'(i)) shift_p0[i] <= serial_in;
            acc_p0 <= acc_p0 ^ serial_in;
            cnt_p0 <= cnt_p0 + 1'b1;
          end
          PARITY: perr_p0 <= (serial_in != exp_parity(acc_p0));
          STOP: begin
            data_out     <= shift_p0;
            parity_error <= perr_p0;
            frame_error  <= ~serial_in;
            data_valid   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench: one even-parity and one odd-parity checker driven by shared
// serial/reset lines with separate bit_valid strobes.
module tb_parity_frame_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, serial_in, bv_e, bv_o;
  logic [7:0] dout_e, dout_o;
  logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

  int total = 0;
  int bad = 0;
  int pulses_e = 0;
  int pulses_o = 0;
  int base;
  bit sel_odd = 1'b0;
  bit in_frame = 1'b0;

  parity_frame_checker #(.N(8), .ODD(1'b0)) dut_even (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bv_e),
    .data_out(dout_e), .data_valid(dv_e), .parity_error(pe_e),
    .frame_error(fe_e), .busy(busy_e)
  );

  parity_frame_checker #(.N(8), .ODD(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bv_o),
    .data_out(dout_o), .data_valid(dv_o), .parity_error(pe_o),
    .frame_error(fe_o), .busy(busy_o)
  );

  always @(posedge clk) begin
    if (dv_e) pulses_e <= pulses_e + 1;
    if (dv_o) pulses_o <= pulses_o + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      tick();
      if (in_frame) check("busy_in_gap", sel_odd ? busy_o : busy_e, 1);
    end
    serial_in = b;
    if (sel_odd) bv_o = 1'b1; else bv_e = 1'b1;
    tick();
    bv_e = 1'b0;
    bv_o = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int maxgap);
    send_bit(1'b0, $urandom_range(0, maxgap));
    in_frame = 1'b1;
    check("busy_after_start", sel_odd ? busy_o : busy_e, 1);
    for (int i = 0; i < 8; i++) send_bit(d[i], $urandom_range(0, maxgap));
    send_bit(par, $urandom_range(0, maxgap));
    send_bit(stop, $urandom_range(0, maxgap));
    in_frame = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check({tag, "_valid"}, sel_odd ? dv_o : dv_e, 1);
    check({tag, "_data"}, sel_odd ? dout_o : dout_e, d);
    check({tag, "_perr"}, sel_odd ? pe_o : pe_e, pe);
    check({tag, "_ferr"}, sel_odd ? fe_o : fe_e, fe);
    check({tag, "_busy"}, sel_odd ? busy_o : busy_e, 0);
  endtask

  initial begin
    reset = 1'b1; serial_in = 1'b1; bv_e = 1'b0; bv_o = 1'b0;
    tick(); tick();
    check("rst_data", dout_e, 0);
    check("rst_valid", dv_e, 0);
    check("rst_perr", pe_e, 0);
    check("rst_ferr", fe_e, 0);
    check("rst_busy", busy_e, 0);
    check("rst_busy_odd", busy_o, 0);
    reset = 1'b0;
    tick();

    // even parity, clean 0x07
    base = pulses_e;
    send_frame(8'h07, 1'b1, 1'b1, 0);
    check_done("f07", 8'h07, 0, 0);
    tick();
    check("f07_pulse_end", dv_e, 0);
    check("f07_pulse_count", pulses_e, base + 1);

    send_frame(8'hFF, 1'b1, 1'b1, 0);
    check_done("fFF", 8'hFF, 1, 0);
    tick();

    send_frame(8'h0F, 1'b0, 1'b0, 0);
    check_done("f0F_stop0", 8'h0F, 0, 1);
    tick(); tick();
    check("hold_valid", dv_e, 0);
    check("hold_data", dout_e, 8'h0F);
    check("hold_ferr", fe_e, 1);

    send_frame(8'h03, 1'b1, 1'b0, 0);
    check_done("f03_both", 8'h03, 1, 1);
    tick();

    // odd parity, back-to-back frames
    sel_odd = 1'b1;
    base = pulses_o;
    send_frame(8'hFE, 1'b0, 1'b1, 0);
    check_done("oFE", 8'hFE, 0, 0);
    send_frame(8'h01, 1'b1, 1'b1, 0);
    check_done("o01", 8'h01, 1, 0);
    tick();
    check("odd_pulse_count", pulses_o, base + 2);

    // even parity with random valid gaps
    sel_odd = 1'b0;
    base = pulses_e;
    send_frame(8'h07, 1'b1, 1'b1, 3);
    check_done("g07", 8'h07, 0, 0);
    tick();
    check("g07_pulse_count", pulses_e, base + 1);

    // long stall mid-frame, then complete
    send_bit(1'b0, 0);
    in_frame = 1'b1;
    send_bit(1'b1, 20);
    for (int i = 1; i < 8; i++) send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    in_frame = 1'b0;
    check_done("stall01", 8'h01, 0, 0);
    tick();

    // reset after 4th data bit, with a valid start-like bit during reset
    base = pulses_e;
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    check("pre_rst_busy", busy_e, 1);
    reset = 1'b1; serial_in = 1'b0; bv_e = 1'b1;
    tick();
    check("mid_rst_busy", busy_e, 0);
    check("mid_rst_data", dout_e, 0);
    check("mid_rst_valid", dv_e, 0);
    check("mid_rst_ferr", fe_e, 0);
    tick();
    bv_e = 1'b0; reset = 1'b0;
    tick(); tick();
    check("post_rst_busy", busy_e, 0);
    check("post_rst_no_pulse", pulses_e, base);
    send_frame(8'h0F, 1'b0, 1'b1, 0);
    check_done("r0F", 8'h0F, 0, 0);
    tick();
    check("r0F_pulse_count", pulses_e, base + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 Parameter N, default 8, number of data bits per frame (N >= 2).
REQ-002 Parameter ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 serial_in  input  1  serial frame bit, sampled only when bit_valid = 1.
REQ-006 bit_valid  input  1  qualifies serial_in for the current cycle.
REQ-007 data_out  output  N  last received data word, LSB-first reassembled.
REQ-008 data_valid  output  1  one-cycle pulse marking frame completion.
REQ-009 parity_error  output  1  received parity bit mismatched the computed parity.
REQ-010 frame_error  output  1  stop bit sampled as 0.
REQ-011 busy  output  1  high from start-bit acceptance until frame completion.

Function
REQ-012 Frame format SHALL be: start bit (0), then N data bits LSB first, then the parity bit, then the stop bit (1).
REQ-013 Only cycles with bit_valid = 1 SHALL advance the FSM, the bit counter, the shift register or the parity accumulator; bit_valid = 0 cycles SHALL hold all state.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY and STOP.
REQ-015 IDLE: a valid bit of 0 SHALL move to DATA and clear the bit counter and parity accumulator; a valid bit of 1 SHALL stay in IDLE (line idle).
REQ-016 DATA: each valid bit SHALL shift into the data register at position count and XOR into the accumulator; after the N-th data bit, the FSM SHALL move to PARITY.
REQ-017 PARITY: the valid bit SHALL be compared with the expected parity and the FSM SHALL move to STOP.
REQ-018 Expected parity SHALL be the XOR of the N data bits when ODD = 0, and its complement when ODD = 1.
REQ-019 STOP: the valid bit SHALL complete the frame, and the FSM SHALL return to IDLE.
REQ-020 data_valid SHALL pulse high for exactly one cycle, in the cycle after the stop bit is sampled.
REQ-021 data_out, parity_error and frame_error SHALL update in that same cycle and hold until the next frame completes.
REQ-022 parity_error and frame_error SHALL be independent; both may assert for the same frame.
REQ-023 A frame with errors SHALL still deliver its data word on data_out with data_valid asserted.
REQ-024 busy SHALL be 1 in DATA, PARITY and STOP, and 0 in IDLE.
REQ-025 A start bit SHALL be accepted on the first valid bit after the stop bit; back-to-back frames SHALL need no idle bits.
REQ-026 The bit counter SHALL be ceil(log2(N+1)) bits wide and SHALL never wrap within a frame.
REQ-027 No timeout SHALL exist: a frame stalled by bit_valid = 0 SHALL wait indefinitely.

Reset
REQ-028 When reset = 1 on a rising edge, the FSM SHALL go to IDLE and the counter and accumulator SHALL clear.
REQ-029 While reset = 1: data_out = 0, data_valid = 0, parity_error = 0, frame_error = 0, busy = 0.
REQ-030 Reset SHALL take priority over bit_valid in the same cycle.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame, and no data_valid pulse SHALL follow.

Verification
REQ-032 Even parity, N=8: bits 0, then data 0x07 LSB first, parity 1, stop 1 -> data_out = 0x07, data_valid pulses once, parity_error = 0, frame_error = 0.
REQ-033 Even parity: data 0xFF, parity 1 -> data_out = 0xFF, parity_error = 1, frame_error = 0.
REQ-034 Even parity: data 0x0F, parity 0, stop 0 -> parity_error = 0, frame_error = 1, data_valid still pulses.
REQ-035 ODD = 1: data 0xFE, parity 0 -> parity_error = 0; then a back-to-back frame with data 0x01, parity 1 -> parity_error = 1 and two data_valid pulses total.
REQ-036 Frame 0x07 with random bit_valid gaps of 0-3 cycles -> same result as REQ-032, and busy stays high throughout the frame.
REQ-037 Reset after the 4th data bit, then a clean 0x0F frame -> no data_valid pulse during reset recovery; data_out = 0x0F with no errors.
